// File: rtl/bombe_crib_search_pkg.sv
// Shared constants, state encoding and character helpers for the shift-cipher Bombe crib search.
package bombe_crib_search_pkg;

  localparam logic [7:0] ORD_A     = 8'd65;
  localparam logic [7:0] ORD_Z     = 8'd90;
  localparam logic [7:0] WILDCARD  = 8'h3F;
  localparam logic [7:0] ERROR_VAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_READY  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ORD_A) && (c <= ORD_Z);
  endfunction

endpackage

// File: rtl/bombe_crib_search_shift_match.sv
// One crib position: does cipher, shifted back by 'shift' letters, equal plain (or is plain a wildcard)?
module shift_match_0_25
  import bombe_crib_search_pkg::*;
#(
  parameter int ALPHA = 26,
  parameter int KEY_W = 5
) (
  input  logic [7:0]       cipher,
  input  logic [7:0]       plain,
  input  logic [KEY_W-1:0] shift,
  output logic             eq
);

  localparam int            W       = KEY_W + 8;
  localparam logic [W-1:0]  ALPHA_W = W'(ALPHA);

  logic [W-1:0] c_off_s;
  logic [W-1:0] p_off_s;
  logic [W-1:0] diff_s;
  logic [W-1:0] red_s;

  // ALPHA is added before subtracting the shift so the difference never goes negative
  always_comb begin
    c_off_s = {{KEY_W{1'b0}}, cipher} - {{KEY_W{1'b0}}, ORD_A};
    p_off_s = {{KEY_W{1'b0}}, plain} - {{KEY_W{1'b0}}, ORD_A};
    diff_s  = c_off_s + ALPHA_W - {8'd0, shift};
    red_s   = (diff_s >= ALPHA_W) ? (diff_s - ALPHA_W) : diff_s;
    eq      = (plain == WILDCARD) || (red_s == p_off_s);
  end

endmodule

// File: rtl/bombe_crib_search.sv
// Crib-search engine: loads cipher/plain pairs, sweeps every key one per tick, reports the
// lowest matching key and the number of matching keys.
module bombe_crib_search
  import bombe_crib_search_pkg::*;
#(
  parameter int CRIB_LEN = 4,
  parameter int STEP     = 1,
  parameter int ALPHA    = 26,
  parameter int KEY_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic [7:0]       plain_in,
  input  logic             char_valid,
  input  logic             go,
  input  logic             clear,
  input  logic             abort,
  input  logic             mode_all,
  input  logic             tick,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             load_err,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W:0]   match_count,
  output logic [7:0]       bombe_out
);

  localparam int               IDX_W    = $clog2(CRIB_LEN + 1);
  localparam int               SW       = KEY_W + 8;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(ALPHA - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic             mode_all_q, mode_all_d;
  logic             found_q, found_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W:0]   count_q, count_d;
  logic             load_err_q, load_err_d;
  logic [7:0]       cipher_q [CRIB_LEN];
  logic [7:0]       cipher_d [CRIB_LEN];
  logic [7:0]       plain_q  [CRIB_LEN];
  logic [7:0]       plain_d  [CRIB_LEN];
  logic             cv_prev_q, go_prev_q;
  logic             busy_q, done_q;
  logic [7:0]       bombe_out_q;

  logic                cv_edge_s, go_edge_s, pair_ok_s, match_s;
  logic [CRIB_LEN-1:0] eq_s;

  assign cv_edge_s = char_valid & ~cv_prev_q;
  assign go_edge_s = go & ~go_prev_q;
  assign pair_ok_s = is_letter(char_in) && (is_letter(plain_in) || (plain_in == WILDCARD));
  assign match_s   = &eq_s;

  // Position i is tested with shift (cand + i*STEP) mod ALPHA; the offset is a constant
  for (genvar gi = 0; gi < CRIB_LEN; gi++) begin : g_pos
    localparam logic [SW-1:0] OFF     = SW'((gi * STEP) % ALPHA);
    localparam logic [SW-1:0] ALPHA_W = SW'(ALPHA);
    logic [SW-1:0]    sum_s;
    logic [KEY_W-1:0] shift_s;

    always_comb begin
      sum_s   = {8'd0, cand_q} + OFF;
      shift_s = (sum_s >= ALPHA_W) ? KEY_W'(sum_s - ALPHA_W) : KEY_W'(sum_s);
    end

    shift_match_0_25 #(.ALPHA(ALPHA), .KEY_W(KEY_W)) u_match (
      .cipher (cipher_q[gi]),
      .plain  (plain_q[gi]),
      .shift  (shift_s),
      .eq     (eq_s[gi])
    );
  end

  // Next-state logic; clear outranks abort, abort outranks tick, tick outranks go
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cand_d     = cand_q;
    mode_all_d = mode_all_q;
    found_d    = found_q;
    key_d      = key_q;
    count_d    = count_q;
    load_err_d = load_err_q;
    cipher_d   = cipher_q;
    plain_d    = plain_q;
    if (clear) begin
      state_d    = ST_LOAD;
      idx_d      = '0;
      cand_d     = '0;
      found_d    = 1'b0;
      key_d      = '0;
      count_d    = '0;
      load_err_d = 1'b0;
      cipher_d   = '{default: 8'd0};
      plain_d    = '{default: 8'd0};
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (cv_edge_s && pair_ok_s) begin
            for (int i = 0; i < CRIB_LEN; i++) begin
              if (idx_q == IDX_W'(i)) begin
                cipher_d[i] = char_in;
                plain_d[i]  = plain_in;
              end else begin
                cipher_d[i] = cipher_q[i];
                plain_d[i]  = plain_q[i];
              end
            end
            idx_d   = idx_q + IDX_W'(1);
            state_d = (idx_q == IDX_W'(CRIB_LEN - 1)) ? ST_READY : ST_LOAD;
          end else if (cv_edge_s) begin
            load_err_d = 1'b1;
          end else begin
            load_err_d = load_err_q;
          end
        end
        ST_READY, ST_DONE: begin
          if (go_edge_s) begin
            state_d    = ST_SEARCH;
            mode_all_d = mode_all;
            cand_d     = '0;
            found_d    = 1'b0;
            key_d      = '0;
            count_d    = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_SEARCH: begin
          if (abort) begin
            state_d = ST_DONE;
          end else if (tick) begin
            if (match_s) begin
              count_d = count_q + (KEY_W + 1)'(1);
              if (!found_q) begin
                found_d = 1'b1;
                key_d   = cand_q;
              end else begin
                key_d = key_q;
              end
            end else begin
              count_d = count_q;
            end
            if ((match_s && !mode_all_q) || (cand_q == LAST_KEY)) begin
              state_d = ST_DONE;
            end else begin
              cand_d = cand_q + KEY_W'(1);
            end
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // State, crib storage and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      cand_q     <= '0;
      mode_all_q <= 1'b0;
      found_q    <= 1'b0;
      key_q      <= '0;
      count_q    <= '0;
      load_err_q <= 1'b0;
      cipher_q   <= '{default: 8'd0};
      plain_q    <= '{default: 8'd0};
      cv_prev_q  <= 1'b0;
      go_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cand_q     <= cand_d;
      mode_all_q <= mode_all_d;
      found_q    <= found_d;
      key_q      <= key_d;
      count_q    <= count_d;
      load_err_q <= load_err_d;
      cipher_q   <= cipher_d;
      plain_q    <= plain_d;
      cv_prev_q  <= char_valid;
      go_prev_q  <= go;
    end
  end

  // Status flags follow the state one cycle later; bombe_out tracks the result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bombe_out_q <= ERROR_VAL;
    end else begin
      busy_q      <= (state_q == ST_SEARCH);
      done_q      <= (state_q == ST_DONE);
      bombe_out_q <= found_d ? {{(8 - KEY_W){1'b0}}, key_d} : ERROR_VAL;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign load_err    = load_err_q;
  assign key_out     = key_q;
  assign match_count = count_q;
  assign bombe_out   = bombe_out_q;

endmodule

// File: tb/tb_bombe_crib_search.sv
// Scoreboard bench for bombe_crib_search: searches push expected results, a monitor checks on done.
module tb_bombe_crib_search;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char_in = 8'd0;
  logic [7:0] plain_in = 8'd0;
  logic       char_valid = 1'b0;
  logic       go = 1'b0;
  logic       clear = 1'b0;
  logic       abort = 1'b0;
  logic       mode_all = 1'b0;
  logic       tick = 1'b0;
  logic       busy, done, found, load_err;
  logic [4:0] key_out;
  logic [5:0] match_count;
  logic [7:0] bombe_out;

  typedef struct {
    logic       found;
    logic [4:0] key;
    logic [5:0] count;
    logic [7:0] bombe;
    int         lat;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  bombe_crib_search dut (
    .clk(clk), .reset(reset), .char_in(char_in), .plain_in(plain_in),
    .char_valid(char_valid), .go(go), .clear(clear), .abort(abort),
    .mode_all(mode_all), .tick(tick), .busy(busy), .done(done), .found(found),
    .load_err(load_err), .key_out(key_out), .match_count(match_count),
    .bombe_out(bombe_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising done retires one scoreboard entry
  always @(negedge clk) begin
    done_prev <= done;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("found", {31'd0, found}, {31'd0, e.found});
        chk("key_out", {27'd0, key_out}, {27'd0, e.key});
        chk("match_count", {26'd0, match_count}, {26'd0, e.count});
        chk("bombe_out", {24'd0, bombe_out}, {24'd0, e.bombe});
        if (e.lat >= 0) chk("latency", cyc - e.start, e.lat);
      end
    end
  end

  task automatic load_pair(input logic [7:0] c, input logic [7:0] p);
    @(negedge clk);
    char_in = c;
    plain_in = p;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic load_crib(input string cs, input string ps);
    for (int i = 0; i < 4; i++) load_pair(cs[i], ps[i]);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // lat = ticks to DONE + 2 (go edge enters SEARCH, done flag is registered from the state)
  task automatic start_search(input logic m, input logic f, input logic [4:0] k,
                              input logic [5:0] n, input logic [7:0] b, input int lat);
    exp_t e;
    @(negedge clk);
    mode_all = m;
    e.found = f; e.key = k; e.count = n; e.bombe = b; e.lat = lat; e.start = cyc;
    sb.push_back(e);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_key", {27'd0, key_out}, 32'd0);
    chk("rst_count", {26'd0, match_count}, 32'd0);
    chk("rst_bombe", {24'd0, bombe_out}, 32'hFF);
    reset = 1'b1;

    // go while still loading must be ignored
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (2) @(negedge clk);
    chk("go_in_load_busy", {31'd0, busy}, 32'd0);

    tick = 1'b1;
    load_crib("DFHJ", "ABCD");
    chk("ready_busy", {31'd0, busy}, 32'd0);
    start_search(1'b0, 1'b1, 5'd3, 6'd1, 8'h03, 6);
    drain(100);
    start_search(1'b1, 1'b1, 5'd3, 6'd1, 8'h03, 28);
    drain(100);

    do_clear();
    load_crib("YZAB", "ZZZZ");
    start_search(1'b0, 1'b1, 5'd25, 6'd1, 8'h19, 28);
    drain(100);

    do_clear();
    load_crib("AAAA", "ABCD");
    start_search(1'b0, 1'b0, 5'd0, 6'd0, 8'hFF, 28);
    drain(100);

    do_clear();
    load_crib("QRST", "????");
    start_search(1'b1, 1'b1, 5'd0, 6'd26, 8'h00, 28);
    drain(100);

    do_clear();
    load_crib("DQQQ", "A???");
    start_search(1'b1, 1'b1, 5'd3, 6'd1, 8'h03, 28);
    drain(100);

    do_clear();
    chk("clear_load_err", {31'd0, load_err}, 32'd0);
    load_pair("1", "A");
    chk("load_err_cipher", {31'd0, load_err}, 32'd1);
    load_pair("B", "a");
    load_crib("DFHJ", "ABCD");
    chk("load_err_sticky", {31'd0, load_err}, 32'd1);
    start_search(1'b0, 1'b1, 5'd3, 6'd1, 8'h03, 6);
    drain(100);
    do_clear();
    chk("load_err_cleared", {31'd0, load_err}, 32'd0);

    // abort with cand=5 after five gated ticks
    tick = 1'b0;
    load_crib("AAAA", "ABCD");
    start_search(1'b0, 1'b0, 5'd0, 6'd0, 8'hFF, -1);
    @(negedge clk); tick = 1'b1;
    repeat (5) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_not_done", {31'd0, done}, 32'd0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    drain(50);

    do_clear();
    load_crib("QRST", "????");
    start_search(1'b1, 1'b1, 5'd0, 6'd5, 8'h00, -1);
    @(negedge clk); tick = 1'b1;
    repeat (5) @(negedge clk);
    tick = 1'b0;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    drain(50);

    // asynchronous reset in the middle of a search
    do_clear();
    tick = 1'b1;
    load_crib("AAAA", "ABCD");
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_bombe", {24'd0, bombe_out}, 32'hFF);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    @(negedge clk); reset = 1'b1;
    load_crib("DFHJ", "ABCD");
    start_search(1'b0, 1'b1, 5'd3, 6'd1, 8'h03, 6);
    drain(100);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
